// File: rtl/par2ser_pkg.sv
// Shared encodings for the parallel-to-serial wrapper: FSM states and channel order.
package par2ser_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic ORD_FWD = 1'b0;
    localparam logic ORD_REV = 1'b1;

endpackage

// File: rtl/par2ser_if.sv
// Producer/consumer bundle for par2ser_wrapper: capture strobe, parallel words and serial stream.
interface par2ser_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 8
);
    logic                       begin_wr;
    logic [NUM_CH*DATA_W-1:0]   din;
    logic                       rev_order;
    logic                       out_ready;
    logic [DATA_W-1:0]          dout;
    logic                       outen;
    logic                       busy;
    logic                       done;

    modport master (
        output begin_wr, din, rev_order, out_ready,
        input  dout, outen, busy, done
    );

    modport slave (
        input  begin_wr, din, rev_order, out_ready,
        output dout, outen, busy, done
    );
endinterface

// File: rtl/par2ser_word_sel.sv
// NUM_CH:1 word multiplexer selecting one DATA_W word from a flattened bank.
module par2ser_word_sel #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 8
) (
    input  logic [NUM_CH*DATA_W-1:0]        bank,
    input  logic [$clog2(NUM_CH)-1:0]       idx,
    output logic [DATA_W-1:0]               word
);
    localparam int unsigned IDX_W = $clog2(NUM_CH);

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                word = bank[k*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: rtl/par2ser_wrapper.sv
// Captures NUM_CH words on begin_wr and streams them one per valid/ready beat,
// in ascending or descending channel order, with busy and a one-cycle done pulse.
module par2ser_wrapper
    import par2ser_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 8
) (
    input logic         clk,
    input logic         rst_n,
    par2ser_if.slave    bus
);
    localparam int unsigned IDX_W  = $clog2(NUM_CH);
    localparam int unsigned BANK_W = NUM_CH * DATA_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                rev_q, rev_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                outen_q, busy_q, done_q, done_d;
    logic [DATA_W-1:0]   sel_word_c;
    logic                last_c;
    logic                hs_c;

    assign hs_c   = outen_q && bus.out_ready;
    assign last_c = (rev_q == ORD_REV) ? (idx_q == '0) : (idx_q == IDX_LAST);

    // Next-state logic: capture in IDLE, step or terminate on each handshake in SEND.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rev_d   = rev_q;
        bank_d  = bank_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.begin_wr) begin
                    bank_d  = bus.din;
                    rev_d   = bus.rev_order;
                    idx_d   = (bus.rev_order == ORD_REV) ? IDX_LAST : '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hs_c) begin
                    if (last_c) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else if (rev_q == ORD_REV) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Select from the next bank/index so dout is registered in the same cycle the index moves.
    par2ser_word_sel #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_word_sel (
        .bank (bank_d),
        .idx  (idx_d),
        .word (sel_word_c)
    );

    assign dout_d = (state_d == ST_SEND) ? sel_word_c : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rev_q   <= ORD_FWD;
            dout_q  <= '0;
            outen_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rev_q   <= rev_d;
            dout_q  <= dout_d;
            outen_q <= (state_d == ST_SEND);
            busy_q  <= (state_d == ST_SEND);
            done_q  <= done_d;
        end
    end

    // Bank contents are don't-care across reset.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign bus.dout  = dout_q;
    assign bus.outen = outen_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_par2ser_wrapper.sv
// Scoreboard bench for par2ser_wrapper: expected words queued at start, checked on each beat.
module tb_par2ser_wrapper;
    import par2ser_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_CH = 8;
    localparam int unsigned BANK_W = NUM_CH * DATA_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    par2ser_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    par2ser_wrapper #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];
    int hs_cnt   = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;
    bit bp_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BANK_W-1:0] make_din(input logic [DATA_W-1:0] base);
        logic [BANK_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) r[k*DATA_W +: DATA_W] = base + DATA_W'(k);
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [BANK_W-1:0] d, input logic rev);
        bus.din       = d;
        bus.rev_order = rev;
        bus.begin_wr  = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            int k;
            k = (rev == ORD_REV) ? (NUM_CH - 1 - i) : i;
            exp_q.push_back(d[k*DATA_W +: DATA_W]);
        end
    endtask

    task automatic wait_done(input int inj_at, input int exp_n, input string tag);
        int  n;
        int  base;
        bit  seen;
        base = hs_cnt;
        seen = 1'b0;
        for (n = 1; n <= 300; n++) begin
            tick();
            if (n == 1) begin
                bus.begin_wr = 1'b0;
                check_val({tag, "_first_outen"}, 32'(bus.outen), 32'd1);
            end
            if (inj_at > 0 && n == inj_at) begin
                bus.din      = '1;
                bus.begin_wr = 1'b1;
            end
            if (inj_at > 0 && n == inj_at + 1) bus.begin_wr = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_val({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            if (exp_n > 0) check_val({tag, "_latency"}, 32'(n), 32'(exp_n));
            check_val({tag, "_beats"}, 32'(hs_cnt - base), 32'(NUM_CH));
            check_val({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    // Backpressure pattern 1,0,0,1 repeating when enabled, else always ready.
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph  = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_en ? pat[ph] : 1'b1;
            ph = (ph + 1) % 4;
        end
    end

    // Output monitor: every valid word must equal the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.outen === 1'b1) begin
                check_val("busy_w_outen", 32'(bus.busy), 32'd1);
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", 32'd1, 32'd0);
                end else begin
                    check_val("dout", 32'(bus.dout), 32'(exp_q[0]));
                    if (bus.out_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                check_val("done_outen", 32'(bus.outen), 32'd0);
                check_val("done_busy",  32'(bus.busy),  32'd0);
                check_val("done_dout",  32'(bus.dout),  32'd0);
                check_val("done_width", 32'(prev_done), 32'd0);
            end
            prev_done = bus.done;
        end
    end

    initial begin
        int base;
        int d0;
        rst_n         = 1'b0;
        bus.begin_wr  = 1'b0;
        bus.din       = '0;
        bus.rev_order = ORD_FWD;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("idle_dout",  32'(bus.dout),  32'd0);
            check_val("idle_outen", 32'(bus.outen), 32'd0);
            check_val("idle_busy",  32'(bus.busy),  32'd0);
            check_val("idle_done",  32'(bus.done),  32'd0);
        end

        start(make_din(8'h00), ORD_FWD);
        wait_done(0, NUM_CH + 1, "fwd");
        tick();

        bp_en = 1'b1;
        start(make_din(8'h00), ORD_REV);
        wait_done(0, 0, "rev_bp");
        bp_en = 1'b0;
        tick();
        tick();

        start(make_din(8'h00), ORD_FWD);
        wait_done(3, NUM_CH + 1, "restart_ign");
        tick();

        start(make_din(8'h00), ORD_FWD);
        wait_done(0, NUM_CH + 1, "b2b_a");
        start(make_din(8'h10), ORD_FWD);
        wait_done(0, NUM_CH + 1, "b2b_b");
        tick();

        base = hs_cnt;
        start(make_din(8'h00), ORD_FWD);
        for (int i = 0; i < 50; i++) begin
            tick();
            bus.begin_wr = 1'b0;
            if (hs_cnt - base >= 3) break;
        end
        check_val("abort_reached", 32'(hs_cnt - base), 32'd3);
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        check_val("abort_outen", 32'(bus.outen), 32'd0);
        check_val("abort_busy",  32'(bus.busy),  32'd0);
        check_val("abort_dout",  32'(bus.dout),  32'd0);
        check_val("abort_done",  32'(bus.done),  32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (3) tick();
        check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);

        start(make_din(8'h20), ORD_FWD);
        wait_done(0, NUM_CH + 1, "post_abort");
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/par2ser_wrapper.md
Name: par2ser_wrapper

Overview:
- Parametrised parallel-to-serial wrapper. Captures NUM_CH words of DATA_W bits on a start strobe, then streams them one word per accepted beat on a single output bus.
- Adds several features: a valid/ready backpressure handshake, a selectable ascending or descending channel order, a busy flag and a completion pulse.
- Sits between a CNN feature/weight producer and a narrow serial consumer in the FPGA CNN datapath.

Parameters:
- DATA_W, 8, bits per channel word and width of dout.
- NUM_CH, 8, number of channels captured per transfer (>=2).
- IDX_W, $clog2(NUM_CH), width of the internal beat index (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- begin_wr  in  1  start strobe; sampled only while busy=0.
- din  in  NUM_CH*DATA_W  flattened channel words; channel k at bits [k*DATA_W +: DATA_W].
- rev_order  in  1  0: emit ch0..chN-1; 1: emit chN-1..ch0. Sampled with begin_wr.
- out_ready  in  1  consumer ready; a beat transfers when outen&&out_ready.
- dout  out  DATA_W  current serial word.
- outen  out  1  dout valid.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last beat transfers.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; dout=0, outen=0, busy=0, done=0; index cleared; captured bank contents are don't-care.
- Reset mid-transfer aborts the transfer. No done pulse is generated, and the remaining beats are discarded.
- All outputs are registered.
- States:
  - IDLE: outen=0, dout=0.
  - On begin_wr=1, capture din into the bank, latch rev_order, set index to 0 (fwd) or NUM_CH-1 (rev), set busy=1, go to SEND.
  - SEND, in the cycle after capture: outen=1, dout=bank[index].
  - SEND, on a handshake (outen&&out_ready) when the beat is not last: step index by +1 (fwd) or -1 (rev). The next word appears on dout in the following cycle and outen stays 1.
  - SEND, when out_ready=0: dout, outen and index hold. Stall length is unbounded.
  - SEND, on a handshake of the last beat (index NUM_CH-1 fwd / 0 rev): next cycle outen=0, dout=0, busy=0, done=1, go to IDLE. done lasts exactly one cycle.
- Latency and throughput:
  - begin_wr at edge t gives first outen=1 at cycle t+1.
  - With out_ready held at 1, NUM_CH consecutive beats occur in cycles t+1..t+NUM_CH, and done=1 in cycle t+NUM_CH+1.
- begin_wr while busy=1 is ignored. It does not alter the bank or restart the transfer.
- begin_wr in the done cycle (busy=0) is accepted, giving exactly one idle cycle between transfers.
- din changes after capture do not affect the words being emitted.
- No arithmetic on data; words pass through bit-exact. The index never wraps, because termination occurs at the end index.

Decomposition:
- Shared package par2ser_pkg holds:
  - the state encoding constants (ST_IDLE, ST_SEND);
  - the order constants (ORD_FWD=0, ORD_REV=1).
- One sub-module: par2ser_word_sel, a parametrised NUM_CH:1 word multiplexer (bank, index -> word). It is instantiated once, and its output feeds the dout register.
- Counter and FSM stay in the top module.

Test Plan:
- Reset/idle: with rst_n=0 for 2 cycles, then 1 and no begin_wr, dout=0, outen=0, busy=0 and done=0 for 10 cycles.
- Forward stream: din = bytes 0x00..0x07 (ch k = k), rev_order=0, out_ready=1, begin_wr pulse at t.
  - dout=0x00..0x07 with outen=1 in cycles t+1..t+8.
  - done=1 at t+9, busy=0.
- Reverse with backpressure: same din, rev_order=1, out_ready toggled 1,0,0,1,... on a fixed pattern.
  - Order is 0x07..0x00, with dout held while out_ready=0.
  - Exactly 8 handshakes, then one done pulse.
- Ignored restart: during a transfer, change din to 0xFF.. and pulse begin_wr.
  - The original sequence completes unchanged, with no extra beats.
- Back-to-back: pulse begin_wr in the done cycle with new din 0x10..0x17.
  - The second stream starts the next cycle and emits 0x10..0x17.
- Abort: assert rst_n=0 after the 3rd beat.
  - Next cycle outen=0, busy=0, dout=0, and no done pulse.
  - A fresh begin_wr afterwards streams correctly from ch0.
